// File: rtl/decode_uop_queue.sv
// Decoded micro-op queue between decode and issue.
// Circular FIFO with valid/ready on both sides and a redirect flush.
module decode_uop_queue #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_pc,
  input  logic [4:0]                 in_src0,
  input  logic [4:0]                 in_src1,
  input  logic [4:0]                 in_dst,
  input  logic [25:0]                in_imm,
  input  logic                       in_pipe_alu,
  input  logic                       in_pipe_mul,
  input  logic                       in_pipe_mem,
  input  logic                       in_pipe_bru,
  input  logic [4:0]                 in_alu_cmd,
  input  logic                       in_mul_cmd,
  input  logic [4:0]                 in_mem_cmd,
  input  logic [6:0]                 in_bru_cmd,
  input  logic [1:0]                 in_bagu_cmd,
  input  logic [1:0]                 in_lswidth,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [4:0]                 out_src0,
  output logic [4:0]                 out_src1,
  output logic [4:0]                 out_dst,
  output logic [25:0]                out_imm,
  output logic                       out_pipe_alu,
  output logic                       out_pipe_mul,
  output logic                       out_pipe_mem,
  output logic                       out_pipe_bru,
  output logic [4:0]                 out_alu_cmd,
  output logic                       out_mul_cmd,
  output logic [4:0]                 out_mem_cmd,
  output logic [6:0]                 out_bru_cmd,
  output logic [1:0]                 out_bagu_cmd,
  output logic [1:0]                 out_lswidth,
  output logic                       out_excp_ri,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  src0;
    logic [4:0]  src1;
    logic [4:0]  dst;
    logic [25:0] imm;
    logic        pipe_alu;
    logic        pipe_mul;
    logic        pipe_mem;
    logic        pipe_bru;
    logic [4:0]  alu_cmd;
    logic        mul_cmd;
    logic [4:0]  mem_cmd;
    logic [6:0]  bru_cmd;
    logic [1:0]  bagu_cmd;
    logic [1:0]  lswidth;
    logic        excp_ri;
  } uop_t;

  uop_t          r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;

  logic w_full;
  logic w_empty;
  logic w_enq;
  logic w_deq;
  uop_t w_new;
  uop_t w_head;

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_enq   = in_valid && !w_full && !flush;
  assign w_deq   = !w_empty && out_ready && !flush;

  always_comb begin
    w_new          = '0;
    w_new.pc       = in_pc;
    w_new.src0     = in_src0;
    w_new.src1     = in_src1;
    w_new.dst      = in_dst;
    w_new.imm      = in_imm;
    w_new.pipe_alu = in_pipe_alu;
    w_new.pipe_mul = in_pipe_mul;
    w_new.pipe_mem = in_pipe_mem;
    w_new.pipe_bru = in_pipe_bru;
    w_new.alu_cmd  = in_alu_cmd;
    w_new.mul_cmd  = in_mul_cmd;
    w_new.mem_cmd  = in_mem_cmd;
    w_new.bru_cmd  = in_bru_cmd;
    w_new.bagu_cmd = in_bagu_cmd;
    w_new.lswidth  = in_lswidth;
    // No pipe selected: issue must raise a reserved-instruction trap
    w_new.excp_ri  = !(in_pipe_alu | in_pipe_mul |
                       in_pipe_mem | in_pipe_bru);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + AW'(1);
      if (w_deq) r_rptr <= r_rptr + AW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_enq) begin
      r_mem[r_wptr] <= w_new;
    end
  end

  assign w_head       = r_mem[r_rptr];
  assign in_ready     = !w_full;
  assign out_valid    = !w_empty;
  assign count        = r_cnt;
  assign out_pc       = w_head.pc;
  assign out_src0     = w_head.src0;
  assign out_src1     = w_head.src1;
  assign out_dst      = w_head.dst;
  assign out_imm      = w_head.imm;
  assign out_pipe_alu = w_head.pipe_alu;
  assign out_pipe_mul = w_head.pipe_mul;
  assign out_pipe_mem = w_head.pipe_mem;
  assign out_pipe_bru = w_head.pipe_bru;
  assign out_alu_cmd  = w_head.alu_cmd;
  assign out_mul_cmd  = w_head.mul_cmd;
  assign out_mem_cmd  = w_head.mem_cmd;
  assign out_bru_cmd  = w_head.bru_cmd;
  assign out_bagu_cmd = w_head.bagu_cmd;
  assign out_lswidth  = w_head.lswidth;
  assign out_excp_ri  = w_head.excp_ri;

endmodule

// File: tb/tb_decode_uop_queue.sv
// Scoreboard bench for decode_uop_queue.
// Outputs are sampled on the falling edge; inputs change 1ns after rising.
module tb_decode_uop_queue;

  localparam int DEPTH = 8;
  localparam logic [4:0] ALU_ADDI = 5'd9;

  logic        clk = 0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_src0, in_src1, in_dst;
  logic [25:0] in_imm;
  logic        in_pipe_alu, in_pipe_mul, in_pipe_mem, in_pipe_bru;
  logic [4:0]  in_alu_cmd;
  logic        in_mul_cmd;
  logic [4:0]  in_mem_cmd;
  logic [6:0]  in_bru_cmd;
  logic [1:0]  in_bagu_cmd, in_lswidth;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_src0, out_src1, out_dst;
  logic [25:0] out_imm;
  logic        out_pipe_alu, out_pipe_mul, out_pipe_mem, out_pipe_bru;
  logic [4:0]  out_alu_cmd;
  logic        out_mul_cmd;
  logic [4:0]  out_mem_cmd;
  logic [6:0]  out_bru_cmd;
  logic [1:0]  out_bagu_cmd, out_lswidth;
  logic        out_excp_ri;
  logic [3:0]  count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [99:0] sb[$];

  always #5 clk = ~clk;

  decode_uop_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_src0(in_src0), .in_src1(in_src1),
    .in_dst(in_dst), .in_imm(in_imm),
    .in_pipe_alu(in_pipe_alu), .in_pipe_mul(in_pipe_mul),
    .in_pipe_mem(in_pipe_mem), .in_pipe_bru(in_pipe_bru),
    .in_alu_cmd(in_alu_cmd), .in_mul_cmd(in_mul_cmd),
    .in_mem_cmd(in_mem_cmd), .in_bru_cmd(in_bru_cmd),
    .in_bagu_cmd(in_bagu_cmd), .in_lswidth(in_lswidth),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_src0(out_src0), .out_src1(out_src1),
    .out_dst(out_dst), .out_imm(out_imm),
    .out_pipe_alu(out_pipe_alu), .out_pipe_mul(out_pipe_mul),
    .out_pipe_mem(out_pipe_mem), .out_pipe_bru(out_pipe_bru),
    .out_alu_cmd(out_alu_cmd), .out_mul_cmd(out_mul_cmd),
    .out_mem_cmd(out_mem_cmd), .out_bru_cmd(out_bru_cmd),
    .out_bagu_cmd(out_bagu_cmd), .out_lswidth(out_lswidth),
    .out_excp_ri(out_excp_ri), .count(count)
  );

  logic [99:0] w_in_vec, w_out_vec;
  assign w_in_vec = {in_pc, in_src0, in_src1, in_dst, in_imm,
    in_pipe_alu, in_pipe_mul, in_pipe_mem, in_pipe_bru,
    in_alu_cmd, in_mul_cmd, in_mem_cmd, in_bru_cmd,
    in_bagu_cmd, in_lswidth,
    ~(in_pipe_alu | in_pipe_mul | in_pipe_mem | in_pipe_bru)};
  assign w_out_vec = {out_pc, out_src0, out_src1, out_dst, out_imm,
    out_pipe_alu, out_pipe_mul, out_pipe_mem, out_pipe_bru,
    out_alu_cmd, out_mul_cmd, out_mem_cmd, out_bru_cmd,
    out_bagu_cmd, out_lswidth, out_excp_ri};

  task automatic chk(input string tag, input logic [99:0] got,
                     input logic [99:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare state to the queue, then apply this cycle's ops
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      chk("count", 100'(count), 100'(sb.size()));
      chk("out_valid", 100'(out_valid), 100'(sb.size() > 0));
      chk("in_ready", 100'(in_ready), 100'(sb.size() < DEPTH));
      if (sb.size() > 0) chk("head", w_out_vec, sb[0]);
      if (flush) begin
        sb.delete();
      end else begin
        logic acc, deq;
        acc = in_valid && (sb.size() < DEPTH);
        deq = out_ready && (sb.size() > 0);
        if (deq) void'(sb.pop_front());
        if (acc) sb.push_back(w_in_vec);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drv(input logic [31:0] pc, input logic [3:0] pipes);
    in_pc       = pc;
    in_src0     = 5'($urandom);
    in_src1     = 5'($urandom);
    in_dst      = 5'($urandom);
    in_imm      = 26'($urandom);
    {in_pipe_alu, in_pipe_mul, in_pipe_mem, in_pipe_bru} = pipes;
    in_alu_cmd  = 5'($urandom);
    in_mul_cmd  = 1'($urandom);
    in_mem_cmd  = 5'($urandom);
    in_bru_cmd  = 7'($urandom);
    in_bagu_cmd = 2'($urandom);
    in_lswidth  = 2'($urandom);
  endtask

  initial begin
    reset = 1; flush = 0; in_valid = 0; out_ready = 0;
    drv(32'h0, 4'b0000);
    #2;
    chk("rst_valid", 100'(out_valid), 100'(0));
    chk("rst_ready", 100'(in_ready), 100'(1));
    chk("rst_count", 100'(count), 100'(0));
    chk("rst_fields", w_out_vec, 100'(0));
    cyc(2);
    reset = 0;
    cyc();

    // single addiu r2,r1,5
    drv(32'h0040_0000, 4'b1000);
    in_src0 = 5'd1; in_src1 = 5'd0; in_dst = 5'd2; in_imm = 26'd5;
    in_alu_cmd = ALU_ADDI;
    in_valid = 1;
    cyc();
    in_valid = 0;
    chk("addiu_pc", 100'(out_pc), 100'(32'h0040_0000));
    chk("addiu_ri", 100'(out_excp_ri), 100'(0));
    chk("addiu_cnt", 100'(count), 100'(1));
    out_ready = 1;
    cyc();
    out_ready = 0;
    chk("addiu_drain", 100'(out_valid), 100'(0));

    // fill, overflow attempt, drain
    for (int i = 0; i < DEPTH; i++) begin
      drv(32'(i * 4), 4'b0100);
      in_valid = 1;
      cyc();
    end
    drv(32'h20, 4'b0010);
    chk("full_ready", 100'(in_ready), 100'(0));
    cyc(2);
    in_valid = 0;
    out_ready = 1;
    cyc(DEPTH);
    out_ready = 0;
    chk("drain_cnt", 100'(count), 100'(0));

    // streaming across pointer wrap
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      drv(32'h1000 + 32'(i * 4), 4'(1 << (i % 4)));
      cyc();
    end
    in_valid = 0;
    cyc();
    out_ready = 0;

    // full with both handshakes
    for (int i = 0; i < DEPTH; i++) begin
      drv(32'h2000 + 32'(i * 4), 4'b0001);
      in_valid = 1;
      cyc();
    end
    drv(32'h2100, 4'b1000);
    out_ready = 1;
    cyc();
    out_ready = 0;
    chk("fb_cnt", 100'(count), 100'(7));
    chk("fb_head", 100'(out_pc), 100'(32'h2004));
    chk("fb_ready", 100'(in_ready), 100'(1));
    cyc();
    in_valid = 0;
    chk("fb_take", 100'(count), 100'(8));

    // flush at count 5
    out_ready = 1;
    cyc(3);
    chk("pre_flush", 100'(count), 100'(5));
    flush = 1; in_valid = 1;
    drv(32'h3000, 4'b1000);
    cyc();
    flush = 0; in_valid = 0; out_ready = 0;
    chk("flush_cnt", 100'(count), 100'(0));
    chk("flush_valid", 100'(out_valid), 100'(0));
    chk("flush_ready", 100'(in_ready), 100'(1));
    drv(32'h3004, 4'b0100);
    in_valid = 1;
    cyc();
    in_valid = 0;
    chk("post_flush", 100'(out_pc), 100'(32'h3004));

    // reserved-instruction entry behind it
    drv(32'h40, 4'b0000);
    in_valid = 1;
    cyc();
    drv(32'h44, 4'b0010);
    cyc();
    in_valid = 0;
    out_ready = 1;
    cyc();
    out_ready = 0;
    chk("ri_pc", 100'(out_pc), 100'(32'h40));
    chk("ri_flag", 100'(out_excp_ri), 100'(1));
    drv(32'h48, 4'b0001);
    in_valid = 1;
    cyc();
    in_valid = 0;
    chk("pre_rst", 100'(count), 100'(3));

    // asynchronous reset mid-cycle
    #1;
    reset = 1;
    #1;
    chk("arst_valid", 100'(out_valid), 100'(0));
    chk("arst_count", 100'(count), 100'(0));
    cyc();
    reset = 0;
    cyc(2);
    chk("arst_after", 100'(out_valid), 100'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
